irq_pending_arb: RTL and testbench
==================================

Name: irq_pending_arb

Overview:
- Request capture and arbitration stage that sits directly upstream of the 8-bit priority encoder.
- Edge-detects 8 request lines into a sticky pending register and applies a mask.
- Selects the highest-index unmasked pending request (bit 7 highest, same priority order as the encoder) and presents its index on a valid/ready handshake.
- Clears the serviced bit on acceptance and flags requests lost to re-assertion while already pending.

Parameters:
- N, 8, number of request lines. Only 8 is supported.
- W, 3, width of the index output. Must equal clog2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  N  level request lines; a 0->1 transition is an event.
- mask  input  N  1 = bit excluded from selection (pending bit is retained).
- ovf_clr  input  1  single-cycle pulse that clears ovf.
- out_valid  output  1  out_num holds a selected request.
- out_num  output  W  index of the selected request.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high at a rising edge.
- pending  output  N  current pending register (status view).
- ovf  output  N  sticky overflow flags, one per line.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pending=0, ovf=0, req_q=0, out_valid=0, out_num=0, FSM=IDLE.
  - Because req_q resets to 0, a req held high through reset counts as an edge on the first cycle after reset.
  - Reset mid-handshake drops the presented request with no acceptance.
- Edge detect: rise = req & ~req_q; req_q <= req every cycle.
- Pending update per bit i, every edge:
  - Set if rise[i].
  - Else cleared if accept and out_num==i.
  - Else held.
  - Set wins over clear in the same cycle: the bit stays 1 and ovf is not flagged.
- Overflow per bit i:
  - Set ovf[i] when rise[i] is high and pending[i] is already 1 (excluding the simultaneous-clear case above).
  - ovf_clr clears all ovf bits. If ovf_clr and a new overflow occur in the same cycle, the new overflow wins.
- Eligible = pending & ~mask, using the registered pending value.
- FSM IDLE:
  - out_valid=0.
  - If eligible != 0: load out_num = highest set index of eligible, assert out_valid, go to PRESENT.
  - Otherwise stay in IDLE.
- FSM PRESENT:
  - out_valid=1 and out_num held stable until accepted.
  - Later higher-priority arrivals and mask changes do not alter or retract the presented index.
  - On accept: clear pending[out_num], drop out_valid on the same edge, go to IDLE.
- Latency:
  - req rise sampled at edge k -> pending set after edge k -> out_valid=1 after edge k+1 (FSM idle).
  - Minimum two cycles per grant: one idle bubble after each accept.
- out_ready while out_valid=0 is ignored. out_num is don't-care when out_valid=0 but holds its last value.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset/latency: hold rst_n=0 with req=8'h00, then release and drive req=8'h10 for one cycle -> pending=8'h10 after 1 edge; out_valid=1, out_num=4 after 2 edges; assert out_ready -> pending=0 and out_valid=0 on the next edge.
- Priority order: raise req=8'h25 in one cycle, out_ready held 1 -> grants come out as 5, 2, 0, each out_valid pulse separated by one idle cycle; pending ends at 0.
- Stability: present index 2, keep out_ready=0, then raise req[7] -> out_num stays 2 until accept; the next grant is 7.
- Mask: pending=8'h81 with mask=8'h80 -> grant 0 only and pending[7] retained; clear the mask -> grant 7 follows.
- Overflow and set-wins-clear:
  - Rise req[3] twice without acceptance -> ovf=8'h08; an ovf_clr pulse returns it to 0.
  - A rise on bit 3 in the same cycle as its accept -> pending[3] stays 1 and ovf stays 0.
- Reset mid-operation: deassert rst_n while out_valid=1 -> all outputs 0 on the next edge; a req held high through reset is captured once after release.

Source files
------------

// File: rtl/irq_pending_arb_if.sv
// Output handshake of the request arbiter: selected index
// presented with valid/ready flow control.
interface irq_pending_arb_if #(
    parameter int W = 3
);
    logic         out_valid;
    logic [W-1:0] out_num;
    logic         out_ready;

    modport master (
        output out_valid,
        output out_num,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_num,
        output out_ready
    );
endinterface

// File: rtl/irq_pending_arb.sv
// Edge-captured sticky pending requests with masking, overflow flags
// and highest-index selection presented over a valid/ready handshake.
module irq_pending_arb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        mask,
    input  logic                ovf_clr,
    irq_pending_arb_if.master   bus,
    output logic [N-1:0]        pending,
    output logic [N-1:0]        ovf
);
    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   req_q;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [N-1:0]   rise, clr, elig;
    logic [W-1:0]   num_q, num_d;
    logic           accept;

    assign rise   = req & ~req_q;
    assign accept = (state_q == PRESENT) && bus.out_ready;
    assign clr    = accept ? (N'(1) << num_q) : '0;
    assign elig   = pend_q & ~mask;

    // A fresh edge wins over the clear of the bit being serviced.
    assign pend_d = rise | (pend_q & ~clr);
    assign ovf_d  = (rise & pend_q & ~clr) | (ovf_clr ? '0 : ovf_q);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    state_d = PRESENT;
                    for (int i = 0; i < N; i++) begin
                        if (elig[i]) num_d = W'(i);
                    end
                end
            end
            PRESENT: begin
                if (accept) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            req_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            req_q   <= req;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_num   = num_q;
    assign pending       = pend_q;
    assign ovf           = ovf_q;
endmodule

// File: tb/tb_irq_pending_arb.sv
// Directed and random checks of irq_pending_arb against a
// per-line behavioural model of requests, grants and overflows.
module tb_irq_pending_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ovf_clr;
    logic [7:0] pending;
    logic [7:0] ovf;

    int errors = 0;
    int checks = 0;

    irq_pending_arb_if #(.W(3)) bus ();

    irq_pending_arb #(.N(8), .W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .ovf_clr (ovf_clr),
        .bus     (bus),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: one flag per line plus "which line is on offer".
    bit m_pend [8];
    bit m_ovf  [8];
    bit m_prev [8];
    bit m_busy;
    int m_num;
    int grants[$];

    function automatic logic [7:0] pack(input bit a [8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_edge();
        bit acc;
        bit old_pend [8];
        int best;
        if (!rst_n) begin
            foreach (m_pend[i]) begin
                m_pend[i] = 0;
                m_ovf[i]  = 0;
                m_prev[i] = 0;
            end
            m_busy = 0;
            m_num  = 0;
            return;
        end
        acc = m_busy && bus.out_ready;
        old_pend = m_pend;
        if (ovf_clr) foreach (m_ovf[i]) m_ovf[i] = 0;
        for (int i = 0; i < 8; i++) begin
            bit rose;
            bit served;
            rose   = req[i] && !m_prev[i];
            served = acc && (m_num == i);
            if (rose) begin
                if (old_pend[i] && !served) m_ovf[i] = 1;
                m_pend[i] = 1;
            end else if (served) begin
                m_pend[i] = 0;
            end
            m_prev[i] = req[i];
        end
        if (m_busy) begin
            if (acc) m_busy = 0;
        end else begin
            best = -1;
            for (int i = 0; i < 8; i++)
                if (old_pend[i] && !mask[i]) best = i;
            if (best >= 0) begin
                m_busy = 1;
                m_num  = best;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        if (bus.out_valid && bus.out_ready && rst_n)
            grants.push_back(int'(bus.out_num));
        @(posedge clk);
        model_edge();
        #1;
        check("valid", {7'd0, bus.out_valid}, {7'd0, m_busy});
        check("num", {5'd0, bus.out_num}, 8'(m_num));
        check("pending", pending, pack(m_pend));
        check("ovf", ovf, pack(m_ovf));
    endtask

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        mask = 8'h00;
        ovf_clr = 1'b0;
        bus.out_ready = 1'b0;
        model_edge();
        repeat (3) cycle();
        check("rst_valid", {7'd0, bus.out_valid}, 8'h00);
        check("rst_pending", pending, 8'h00);

        // Reset release and latency
        rst_n = 1'b1;
        req = 8'h10;
        cycle();
        check("lat_pend", pending, 8'h10);
        check("lat_v0", {7'd0, bus.out_valid}, 8'h00);
        req = 8'h00;
        cycle();
        check("lat_v1", {7'd0, bus.out_valid}, 8'h01);
        check("lat_num", {5'd0, bus.out_num}, 8'd4);
        bus.out_ready = 1'b1;
        cycle();
        check("lat_clr", pending, 8'h00);
        check("lat_drop", {7'd0, bus.out_valid}, 8'h00);

        // Priority order 5, 2, 0
        grants.delete();
        req = 8'h25;
        cycle();
        req = 8'h00;
        repeat (7) cycle();
        check("prio_n", 8'(grants.size()), 8'd3);
        if (grants.size() == 3) begin
            check("prio_g0", 8'(grants[0]), 8'd5);
            check("prio_g1", 8'(grants[1]), 8'd2);
            check("prio_g2", 8'(grants[2]), 8'd0);
        end
        check("prio_end", pending, 8'h00);

        // Presented index stays put under a higher arrival
        bus.out_ready = 1'b0;
        req = 8'h04;
        cycle();
        req = 8'h00;
        cycle();
        req = 8'h80;
        cycle();
        req = 8'h00;
        repeat (2) cycle();
        check("stab_num", {5'd0, bus.out_num}, 8'd2);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        check("stab_next", {5'd0, bus.out_num}, 8'd7);
        cycle();

        // Mask retains pending bit
        bus.out_ready = 1'b0;
        mask = 8'h80;
        req = 8'h81;
        cycle();
        req = 8'h00;
        cycle();
        check("mask_num", {5'd0, bus.out_num}, 8'd0);
        bus.out_ready = 1'b1;
        cycle();
        check("mask_keep", pending, 8'h80);
        cycle();
        check("mask_idle", {7'd0, bus.out_valid}, 8'h00);
        mask = 8'h00;
        cycle();
        check("mask_g7", {5'd0, bus.out_num}, 8'd7);
        cycle();

        // Overflow, clear, and set-wins-clear
        bus.out_ready = 1'b0;
        req = 8'h08;
        cycle();
        req = 8'h00;
        cycle();
        req = 8'h08;
        cycle();
        check("ovf_set", ovf, 8'h08);
        req = 8'h00;
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 8'h00);
        req = 8'h08;
        bus.out_ready = 1'b1;
        cycle();
        check("swc_pend", pending & 8'h08, 8'h08);
        check("swc_ovf", ovf, 8'h00);
        req = 8'h00;
        repeat (3) cycle();
        check("swc_end", pending, 8'h00);

        // Reset mid-handshake; held request captured once
        bus.out_ready = 1'b0;
        req = 8'h02;
        repeat (2) cycle();
        check("mid_v", {7'd0, bus.out_valid}, 8'h01);
        rst_n = 1'b0;
        cycle();
        check("mid_v0", {7'd0, bus.out_valid}, 8'h00);
        check("mid_num", {5'd0, bus.out_num}, 8'h00);
        check("mid_pend", pending, 8'h00);
        rst_n = 1'b1;
        cycle();
        check("mid_cap", pending, 8'h02);
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        check("mid_once", pending, 8'h00);
        req = 8'h00;
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            req = 8'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        ovf_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
